// File: rtl/test_sequencer.sv
// test_sequencer: drives LFSR vectors into a DUT and folds its responses into a rotating-XOR signature
// Optional watchdog is enabled by defining TEST_SEQUENCER_TIMEOUT_EN.
module test_sequencer #(
    parameter int         NUM_VEC    = 16,
    parameter int         RST_CYCLES = 2,
    parameter logic [7:0] SEED       = 8'h01,
    parameter logic [7:0] GOLDEN     = 8'h00,
    parameter int         TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_rst,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    input  logic       vec_ready,
    input  logic       resp_valid,
    input  logic [7:0] resp_data,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       timed_out,
    output logic [7:0] signature,
    output logic [7:0] vec_count
);
    typedef enum logic [2:0] {IDLE, RESET, APPLY, WAIT_RESP, DONE} state_t;
    state_t     r_state, w_next;
    logic [7:0] r_lfsr, r_sig, r_count;
    logic [3:0] r_rst_cnt;
    logic       r_done, r_pass;
    logic       w_start, w_rst_end, w_vec_hs, w_resp_hs, w_last, w_to;
    logic [7:0] w_sig_nxt, w_cnt_nxt;

    assign w_start   = start && (r_state == IDLE || r_state == DONE);
    assign w_rst_end = r_state == RESET && r_rst_cnt == 4'(RST_CYCLES);
    assign w_vec_hs  = r_state == APPLY && vec_ready;
    assign w_resp_hs = r_state == WAIT_RESP && resp_valid;
    assign w_sig_nxt = {r_sig[6:0], r_sig[7]} ^ resp_data;
    assign w_cnt_nxt = r_count + 8'd1;
    assign w_last    = w_cnt_nxt == 8'(NUM_VEC);

`ifdef TEST_SEQUENCER_TIMEOUT_EN
    logic [7:0] r_wd;
    logic       r_timed_out;
    assign w_to      = (r_state == APPLY || r_state == WAIT_RESP) && !w_vec_hs && !w_resp_hs && r_wd == 8'(TIMEOUT - 1);
    assign timed_out = r_timed_out;
    // watchdog: counts stalled cycles, restarts on every handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd        <= '0;
            r_timed_out <= 1'b0;
        end else if (w_start) begin
            r_wd        <= '0;
            r_timed_out <= 1'b0;
        end else if (w_to) begin
            r_wd        <= '0;
            r_timed_out <= 1'b1;
        end else if (w_vec_hs || w_resp_hs) begin
            r_wd <= '0;
        end else if (r_state == APPLY || r_state == WAIT_RESP) begin
            r_wd <= r_wd + 8'd1;
        end
    end
`else
    assign w_to      = 1'b0;
    assign timed_out = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next-state selection; a timeout or final response lands in DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = w_start ? RESET : r_state;
            RESET:      w_next = w_rst_end ? APPLY : RESET;
            APPLY:      w_next = w_vec_hs ? WAIT_RESP : (w_to ? DONE : APPLY);
            WAIT_RESP:  w_next = w_resp_hs ? (w_last ? DONE : APPLY) : (w_to ? DONE : WAIT_RESP);
            default:    w_next = IDLE;
        endcase
    end

    // datapath: LFSR, signature, response count and verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr    <= SEED;
            r_sig     <= '0;
            r_count   <= '0;
            r_rst_cnt <= '0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            if (w_start) begin
                r_lfsr    <= SEED;
                r_sig     <= '0;
                r_count   <= '0;
                r_rst_cnt <= '0;
                r_done    <= 1'b0;
                r_pass    <= 1'b0;
            end
            if (r_state == RESET && !w_rst_end) r_rst_cnt <= r_rst_cnt + 4'd1;
            if (w_vec_hs) r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            if (w_resp_hs) begin
                r_sig   <= w_sig_nxt;
                r_count <= w_cnt_nxt;
                if (w_last) begin
                    r_done <= 1'b1;
                    r_pass <= w_sig_nxt == GOLDEN;
                end
            end
            if (w_to) begin
                r_done <= 1'b1;
                r_pass <= 1'b0;
            end
        end
    end

    assign dut_rst   = r_state == IDLE || r_state == RESET || r_state == DONE;
    assign vec_valid = r_state == APPLY;
    assign vec_data  = r_lfsr;
    assign busy      = r_state == RESET || r_state == APPLY || r_state == WAIT_RESP;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = r_sig;
    assign vec_count = r_count;
endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: directed checks of the default sequencer and a one-vector 5A configuration
module tb_test_sequencer;
    logic       clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0;
    logic       vec_ready = 1'b0, resp_valid = 1'b0;
    logic [7:0] resp_data = 8'h00;
    logic       dut_rst0, vv0, busy0, done0, pass0, to0;
    logic [7:0] vd0, sig0, cnt0;
    logic       dut_rst1, vv1, busy1, done1, pass1, to1;
    logic [7:0] vd1, sig1, cnt1;
    int         n_chk = 0, n_err = 0;
    logic [7:0] exp_l, exp_s;
    logic [7:0] first5 [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};

    always #5 clk = ~clk;

    test_sequencer u0 (
        .clk(clk), .rst(rst), .start(start0), .dut_rst(dut_rst0), .vec_valid(vv0), .vec_data(vd0),
        .vec_ready(vec_ready), .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy0),
        .done(done0), .pass(pass0), .timed_out(to0), .signature(sig0), .vec_count(cnt0)
    );

    test_sequencer #(.NUM_VEC(1), .SEED(8'h5A), .GOLDEN(8'h5A)) u1 (
        .clk(clk), .rst(rst), .start(start1), .dut_rst(dut_rst1), .vec_valid(vv1), .vec_data(vd1),
        .vec_ready(vec_ready), .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy1),
        .done(done1), .pass(pass1), .timed_out(to1), .signature(sig1), .vec_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] sig_step(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], s[7]} ^ d;
    endfunction

    // one response cycle: the sequencer is in APPLY at entry and vec_ready is already 1
    task automatic respond(input logic [7:0] d);
        @(negedge clk);
        chk("wait_no_valid", vv0 | vv1, 0);
        resp_valid = 1'b1;
        resp_data  = d;
        @(negedge clk);
        resp_valid = 1'b0;
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        chk("rst_dut_rst", dut_rst0, 1);
        chk("rst_vec_valid", vv0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_timed_out", to0, 0);
        chk("rst_signature", sig0, 0);
        chk("rst_vec_count", cnt0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_holds", busy0, 0);

        // start timing and full echo run
        vec_ready = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("n0_dut_rst", dut_rst0, 1);
        chk("n0_busy", busy0, 1);
        chk("n0_vec_valid", vv0, 0);
        repeat (2) begin
            @(negedge clk);
            chk("n12_dut_rst", dut_rst0, 1);
            chk("n12_vec_valid", vv0, 0);
        end
        @(negedge clk);
        chk("n3_vec_valid", vv0, 1);
        chk("n3_dut_rst", dut_rst0, 0);
        exp_l = 8'h01;
        exp_s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            chk("echo_valid", vv0, 1);
            chk("echo_data", vd0, exp_l);
            if (i < 5) chk("echo_table", vd0, first5[i]);
            exp_s = sig_step(exp_s, exp_l);
            respond(exp_l);
            exp_l = lfsr_step(exp_l);
        end
        chk("echo_done", done0, 1);
        chk("echo_busy", busy0, 0);
        chk("echo_count", cnt0, 16);
        chk("echo_sig", sig0, exp_s);
        chk("echo_pass", pass0, exp_s == 8'h00);
        chk("echo_dut_rst", dut_rst0, 1);
        resp_valid = 1'b1;
        resp_data  = 8'hFF;
        @(negedge clk);
        resp_valid = 1'b0;
        chk("ignore_resp_sig", sig0, exp_s);
        chk("ignore_resp_cnt", cnt0, 16);
        chk("ignore_resp_done", done0, 1);

        // backpressure: vector held while vec_ready is low
        vec_ready = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("restart_clear_done", done0, 0);
        chk("restart_clear_cnt", cnt0, 0);
        repeat (3) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", vv0, 1);
            chk("stall_data", vd0, 8'h01);
        end
        vec_ready = 1'b1;
        respond(8'h01);
        chk("stall_advance_once", vd0, 8'h02);
        respond(8'h02);
        respond(8'h04);
        chk("pre_rst_data", vd0, 8'h08);
        @(negedge clk);
        chk("pre_rst_count", cnt0, 3);
        chk("pre_rst_wait", vv0, 0);

        // asynchronous reset mid-run, away from a clock edge
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy0, 0);
        chk("arst_dut_rst", dut_rst0, 1);
        chk("arst_count", cnt0, 0);
        chk("arst_sig", sig0, 0);
        chk("arst_data", vd0, 8'h01);
        chk("arst_valid", vv0, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        resp_valid = 1'b1;
        resp_data  = 8'hAA;
        @(negedge clk);
        resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_count", cnt0, 0);
        chk("post_rst_sig", sig0, 0);
        chk("post_rst_busy", busy0, 0);

        // one-vector configuration, matching and mismatching response
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("cfg_data", vd1, 8'h5A);
        respond(8'h5A);
        chk("cfg_sig", sig1, 8'h5A);
        chk("cfg_done", done1, 1);
        chk("cfg_pass", pass1, 1);
        chk("cfg_count", cnt1, 1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        respond(8'h00);
        chk("cfg_bad_sig", sig1, 8'h00);
        chk("cfg_bad_done", done1, 1);
        chk("cfg_bad_pass", pass1, 0);

        // no response ever arrives
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
`ifdef TEST_SEQUENCER_TIMEOUT_EN
        k = 0;
        while (!done0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("to_cycles", k, 68);
        chk("to_flag", to0, 1);
        chk("to_pass", pass0, 0);
        chk("to_busy", busy0, 0);
`else
        k = 0;
        repeat (200) @(negedge clk);
        chk("hang_busy", busy0, 1);
        chk("hang_done", done0, 0);
        chk("hang_timed_out", to0, 0);
        chk("hang_idle_cycles", k, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_VEC, default 16, which sets the number of vectors per run (1..255).
REQ-002 The block SHALL have parameter RST_CYCLES, default 2, which sets the number of cycles dut_rst is held after start (1..15).
REQ-003 The block SHALL have parameter SEED, default 8'h01, which is the nonzero initial value of the vector LFSR.
REQ-004 The block SHALL have parameter GOLDEN, default 8'h00, which is the expected final signature.
REQ-005 The block SHALL have parameter TIMEOUT, default 64, which is the handshake watchdog limit in cycles (1..255).
REQ-006 The block SHALL have the following ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request.
- dut_rst  output  1  reset to the DUT.
- vec_valid  output  1  vector offered.
- vec_data  output  8  vector.
- vec_ready  input  1  DUT accepts vector.
- resp_valid  input  1  DUT response strobe.
- resp_data  input  8  response.
- busy  output  1  run in progress.
- done  output  1  run finished.
- pass  output  1  result.
- timed_out  output  1  watchdog fired.
- signature  output  8  accumulated signature.
- vec_count  output  8  responses accepted.

Function
REQ-007 The block SHALL implement the states IDLE, RESET, APPLY, WAIT_RESP and DONE.
REQ-008 In IDLE and DONE, start=1 SHALL enter RESET and, in the same cycle, load lfsr=SEED and clear signature, vec_count, done, pass, timed_out and the RESET/watchdog counters.
REQ-009 RESET SHALL hold dut_rst=1 for exactly RST_CYCLES cycles, then enter APPLY; vec_valid SHALL first assert RST_CYCLES+1 cycles after the start edge.
REQ-010 dut_rst SHALL be 1 in IDLE, RESET and DONE, and 0 in APPLY and WAIT_RESP.
REQ-011 APPLY SHALL drive vec_valid=1 and vec_data=lfsr; vec_data SHALL be held stable while vec_valid=1 and vec_ready=0.
REQ-012 On vec_valid and vec_ready in APPLY, the block SHALL set lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]} and enter WAIT_RESP, and SHALL drive vec_valid=0 from the next cycle.
REQ-013 In WAIT_RESP, resp_valid=1 SHALL set signature <= {signature[6:0], signature[7]} ^ resp_data and increment vec_count; the block SHALL then enter DONE if the new vec_count equals NUM_VEC, else APPLY.
REQ-014 resp_valid outside WAIT_RESP SHALL be ignored with no state change.
REQ-015 start while busy=1 SHALL be ignored.
REQ-016 busy SHALL be 1 in RESET, APPLY and WAIT_RESP, and 0 otherwise.
REQ-017 On entry to DONE the block SHALL set done=1 and pass=(signature==GOLDEN && !timed_out); done, pass and signature SHALL hold until the next start or rst.
REQ-018 vec_count SHALL never wrap; NUM_VEC is at most 255.

Reset
REQ-019 rst=1 SHALL asynchronously force state IDLE, dut_rst=1, vec_valid=0, busy=0, done=0, pass=0, timed_out=0, signature=0, vec_count=0, lfsr=SEED and all counters to 0, including mid-run.
REQ-020 After rst deasserts, the block SHALL wait in IDLE for start and SHALL NOT auto-resume an interrupted run.

Configuration
REQ-021 With TEST_SEQUENCER_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in APPLY or WAIT_RESP, clearing on each completed handshake; reaching TIMEOUT SHALL set timed_out=1 and enter DONE with pass=0.
REQ-022 Without TEST_SEQUENCER_TIMEOUT_EN, there SHALL be no watchdog logic, timed_out SHALL be tied 0, and the block SHALL wait indefinitely.

Verification
REQ-023 Bench SHALL cover: defaults, vec_ready=1, responses echo vectors -> vec_data sequence 01,02,04,08,11,... and vec_count=16 at done.
REQ-024 Bench SHALL cover: start pulse at edge N -> dut_rst=1 through N+2, vec_valid=1 from N+3.
REQ-025 Bench SHALL cover: NUM_VEC=1, SEED=8'h5A, GOLDEN=8'h5A, response 8'h5A -> signature=8'h5A, done=1, pass=1; the same run with response 8'h00 -> pass=0.
REQ-026 Bench SHALL cover: vec_ready held 0 for 5 cycles -> vec_data held constant, and no lfsr advance.
REQ-027 Bench SHALL cover: rst pulsed in WAIT_RESP at vec_count=3 -> all outputs at reset values immediately, and resp_valid is then ignored.
REQ-028 Bench SHALL cover: with TIMEOUT_EN and TIMEOUT=64, resp_valid never asserted -> DONE after 64 cycles, timed_out=1, pass=0; without the macro, busy stays 1.
